// File: rtl/car_alarm_driver.sv
// Car alarm buzzer/lamp driver: grace delay after Alarm rises, a bounded train
// of buzzer pulses, then self-mute; driver Ack mutes early.
module car_alarm_driver #(
    parameter int GRACE_CYC = 8,
    parameter int ON_CYC    = 4,
    parameter int OFF_CYC   = 4,
    parameter int MAX_BEEPS = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic Alarm,
    input  logic Ack,
    output logic Buzzer,
    output logic Lamp,
    output logic Muted
);

    typedef enum logic [2:0] {IDLE, ARM, BEEP_ON, BEEP_OFF, MUTED} state_t;

    localparam logic [7:0] GRACE_LAST = 8'(GRACE_CYC - 1);
    localparam logic [7:0] ON_LAST    = 8'(ON_CYC - 1);
    localparam logic [7:0] OFF_LAST   = 8'(OFF_CYC - 1);
    localparam logic [7:0] BEEP_LAST  = 8'(MAX_BEEPS);

    state_t     state;
    logic [7:0] phase;
    logic [7:0] beeps;

    // {Buzzer, Lamp, Muted} for the state being entered, so outputs stay registered
    function automatic logic [2:0] decode(input state_t s);
        case (s)
            BEEP_ON:  decode = 3'b110;
            BEEP_OFF: decode = 3'b010;
            MUTED:    decode = 3'b011;
            default:  decode = 3'b000;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                  <= IDLE;
            phase                  <= 8'd0;
            beeps                  <= 8'd0;
            {Buzzer, Lamp, Muted}  <= 3'b000;
        end else if (!Alarm) begin
            // Losing the alarm beats Ack and any phase-end transition
            state                  <= IDLE;
            phase                  <= 8'd0;
            beeps                  <= 8'd0;
            {Buzzer, Lamp, Muted}  <= decode(IDLE);
        end else begin
            case (state)
                IDLE: begin
                    state                 <= ARM;
                    phase                 <= 8'd0;
                    beeps                 <= 8'd0;
                    {Buzzer, Lamp, Muted} <= decode(ARM);
                end
                ARM: begin
                    if (phase == GRACE_LAST) begin
                        state                 <= BEEP_ON;
                        phase                 <= 8'd0;
                        beeps                 <= 8'd1;
                        {Buzzer, Lamp, Muted} <= decode(BEEP_ON);
                    end else begin
                        phase <= phase + 8'd1;
                    end
                end
                BEEP_ON: begin
                    if (Ack) begin
                        state                 <= MUTED;
                        {Buzzer, Lamp, Muted} <= decode(MUTED);
                    end else if (phase == ON_LAST) begin
                        state                 <= BEEP_OFF;
                        phase                 <= 8'd0;
                        {Buzzer, Lamp, Muted} <= decode(BEEP_OFF);
                    end else begin
                        phase <= phase + 8'd1;
                    end
                end
                BEEP_OFF: begin
                    if (Ack) begin
                        state                 <= MUTED;
                        {Buzzer, Lamp, Muted} <= decode(MUTED);
                    end else if (phase == OFF_LAST) begin
                        phase <= 8'd0;
                        if (beeps == BEEP_LAST) begin
                            state                 <= MUTED;
                            {Buzzer, Lamp, Muted} <= decode(MUTED);
                        end else begin
                            state                 <= BEEP_ON;
                            beeps                 <= beeps + 8'd1;
                            {Buzzer, Lamp, Muted} <= decode(BEEP_ON);
                        end
                    end else begin
                        phase <= phase + 8'd1;
                    end
                end
                MUTED: begin
                    state                 <= MUTED;
                    {Buzzer, Lamp, Muted} <= decode(MUTED);
                end
                default: begin
                    state                 <= IDLE;
                    phase                 <= 8'd0;
                    beeps                 <= 8'd0;
                    {Buzzer, Lamp, Muted} <= decode(IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_car_alarm_driver.sv
// Scoreboard bench: default and 1/1/1/1 corner instances share stimulus; a
// timeline model of each episode predicts the outputs after every edge.
module tb_car_alarm_driver;

    logic clk = 1'b0;
    logic rst_n;
    logic alarm;
    logic ack;
    logic buz_d, lamp_d, mute_d;
    logic buz_c, lamp_c, mute_c;

    always #5 clk = ~clk;

    car_alarm_driver dut_d (
        .clk(clk), .rst_n(rst_n), .Alarm(alarm), .Ack(ack),
        .Buzzer(buz_d), .Lamp(lamp_d), .Muted(mute_d)
    );

    car_alarm_driver #(.GRACE_CYC(1), .ON_CYC(1), .OFF_CYC(1), .MAX_BEEPS(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .Alarm(alarm), .Ack(ack),
        .Buzzer(buz_c), .Lamp(lamp_c), .Muted(mute_c)
    );

    int tests = 0;
    int fails = 0;
    bit done  = 1'b0;
    logic [5:0] sb[$];

    // Model state: number of consecutive Alarm=1 edges in this episode, and an Ack latch
    int td = 0, tc = 0;
    bit md = 1'b0, mc = 1'b0;

    task automatic upd(inout int t, inout bit m, input int g, input int on, input int off,
                       input int mx, input bit r, input bit a, input bit k);
        int s;
        bit beeping;
        if (!r || !a) begin
            t = 0;
            m = 1'b0;
        end else begin
            s = t - (g + 1);
            beeping = (t >= g + 1) && !m && (s < mx * (on + off));
            if (beeping && k) m = 1'b1;
            if (t < 100000) t = t + 1;
        end
    endtask

    function automatic logic [2:0] expect_out(input int t, input bit m, input int g,
                                              input int on, input int off, input int mx);
        int s;
        if (t < g + 1) return 3'b000;
        s = t - (g + 1);
        if (m || s >= mx * (on + off)) return 3'b011;
        return ((s % (on + off)) < on) ? 3'b110 : 3'b010;
    endfunction

    task automatic step(input bit r, input bit a, input bit k);
        rst_n = r;
        alarm = a;
        ack   = k;
        upd(td, md, 8, 4, 4, 5, r, a, k);
        upd(tc, mc, 1, 1, 1, 1, r, a, k);
        sb.push_back({expect_out(td, md, 8, 4, 4, 5), expect_out(tc, mc, 1, 1, 1, 1)});
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit r, input bit a, input bit k);
        for (int i = 0; i < n; i++) step(r, a, k);
    endtask

    // Monitor: outputs are valid after every edge, so one entry is consumed per edge
    initial begin
        logic [5:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                if (!done) begin
                    tests++;
                    fails++;
                    $display("FAIL scoreboard_empty at %0t", $time);
                end
            end else begin
                e = sb.pop_front();
                tests++;
                if ({buz_d, lamp_d, mute_d} !== e[5:3]) begin
                    fails++;
                    $display("FAIL dflt_outputs t=%0t buz/lamp/mute got=%b exp=%b",
                             $time, {buz_d, lamp_d, mute_d}, e[5:3]);
                end
                tests++;
                if ({buz_c, lamp_c, mute_c} !== e[2:0]) begin
                    fails++;
                    $display("FAIL corner_outputs t=%0t buz/lamp/mute got=%b exp=%b",
                             $time, {buz_c, lamp_c, mute_c}, e[2:0]);
                end
            end
        end
    end

    initial begin
        // Reset held with Alarm high, then a long hold through the full pulse train
        run(3, 1'b0, 1'b1, 1'b0);
        run(100, 1'b1, 1'b1, 1'b0);
        run(2, 1'b1, 1'b0, 1'b0);
        // Short glitch never reaches the buzzer
        run(5, 1'b1, 1'b1, 1'b0);
        run(3, 1'b1, 1'b0, 1'b0);
        // Ack in 2nd cycle of pulse 2, then Ack together with Alarm low
        run(18, 1'b1, 1'b1, 1'b0);
        run(1, 1'b1, 1'b1, 1'b1);
        run(3, 1'b1, 1'b1, 1'b0);
        run(1, 1'b1, 1'b0, 1'b1);
        run(2, 1'b1, 1'b0, 1'b0);
        // Ack while arming is ignored
        run(4, 1'b1, 1'b1, 1'b1);
        run(12, 1'b1, 1'b1, 1'b0);
        run(1, 1'b1, 1'b0, 1'b0);
        // Drop in 3rd cycle of pulse 1, re-rise two cycles later
        run(11, 1'b1, 1'b1, 1'b0);
        run(2, 1'b1, 1'b0, 1'b0);
        run(20, 1'b1, 1'b1, 1'b0);
        // Reset mid-pulse
        run(1, 1'b0, 1'b1, 1'b0);
        run(12, 1'b1, 1'b1, 1'b0);
        run(1, 1'b1, 1'b0, 1'b0);
        // Randomized episodes
        for (int blk = 0; blk < 60; blk++) begin
            int len;
            bit a;
            len = $urandom_range(1, 70);
            a   = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < len; i++)
                step($urandom_range(0, 99) != 0, a, $urandom_range(0, 15) == 0);
        end
        done = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
